ahb_req_concatenator: RTL and testbench

AHB-Lite slave front end of the AHB-to-APB bridge, on the write side of the request FIFO. It accepts AHB transfers and packs each one into a single request word. The packed fields are address, direction, protection, byte strobes and write data. Each word is pushed into the asynchronous request FIFO, where the APB side unpacks it; the block also returns read data from the response FIFO to the AHB master.

---
 rtl/ahb_req_concatenator.sv | 128 ++++++++++++
 tb/tb_ahb_req_concatenator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_concatenator.sv
// AHB-Lite slave front end of the AHB-to-APB bridge. It packs each AHB transfer into one
// request word for the async request FIFO and returns read data from the response FIFO.
module ahb_req_concatenator #(
    parameter int unsigned DATASIZE           = 32,
    parameter int unsigned ADDRSIZE           = 32,
    parameter int unsigned TOP_FIFO_DATA_SIZE = DATASIZE + ADDRSIZE + 4 + DATASIZE / 8
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic                          HSEL,
    input  logic [1:0]                    HTRANS,
    input  logic                          HWRITE,
    input  logic [ADDRSIZE-1:0]           HADDR,
    input  logic [2:0]                    HSIZE,
    input  logic [3:0]                    HPROT,
    input  logic [DATASIZE-1:0]           HWDATA,
    input  logic                          HREADY,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [DATASIZE-1:0]           HRDATA,
    input  logic                          wfull,
    output logic                          winc,
    output logic [TOP_FIFO_DATA_SIZE-1:0] conc_data_fifo,
    input  logic                          rd_rempty,
    input  logic [DATASIZE-1:0]           rd_rdata,
    output logic                          rd_rinc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RWAIT = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [ADDRSIZE-1:0]  addr_q;
    logic                 write_q;
    logic [2:0]           size_q;
    logic [2:0]           pprot_q;

    logic                 accept_c;
    logic                 load_c;
    logic                 word_en_c;
    logic [3:0]           strb_c;
    logic [DATASIZE-1:0]  wdata_c;
    logic                 unused_c;

    assign accept_c = HSEL & HTRANS[1] & HREADY;
    assign HRESP    = 1'b0;
    assign unused_c = ^{HTRANS[0], HPROT[3:2]};

    // State register and address-phase capture
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            pprot_q <= 3'd0;
        end else begin
            state_q <= state_d;
            if (load_c) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
                pprot_q <= {~HPROT[0], 1'b0, HPROT[1]};
            end
        end
    end

    // Next state and bus/FIFO handshakes
    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        winc      = 1'b0;
        rd_rinc   = 1'b0;
        HRDATA    = '0;
        load_c    = 1'b0;
        word_en_c = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = accept_c;
            end
            WR: begin
                HREADYOUT = ~wfull;
                winc      = ~wfull;
                word_en_c = 1'b1;
                load_c    = accept_c & ~wfull;
                if (!wfull) state_d = IDLE;
            end
            RD: begin
                HREADYOUT = 1'b0;
                winc      = ~wfull;
                word_en_c = 1'b1;
                if (!wfull) state_d = RWAIT;
            end
            RWAIT: begin
                HREADYOUT = ~rd_rempty;
                rd_rinc   = ~rd_rempty;
                HRDATA    = rd_rdata;
                load_c    = accept_c & ~rd_rempty;
                if (!rd_rempty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A transfer accepted while completing the current one chains directly
        if (load_c) state_d = HWRITE ? WR : RD;
    end

    // Write strobes from captured size and low address bits
    always_comb begin
        strb_c = 4'b0000;
        if (write_q) begin
            case (size_q)
                3'd0:    strb_c = 4'b0001 << addr_q[1:0];
                3'd1:    strb_c = addr_q[1] ? 4'b1100 : 4'b0011;
                default: strb_c = 4'b1111;
            endcase
        end
    end

    assign wdata_c        = write_q ? HWDATA : '0;
    assign conc_data_fifo = word_en_c
                          ? TOP_FIFO_DATA_SIZE'({wdata_c, strb_c, pprot_q, addr_q, write_q})
                          : '0;

endmodule

// File: tb/tb_ahb_req_concatenator.sv
// Directed bench for ahb_req_concatenator: writes, strobes, FIFO-full stalls, reads,
// back-to-back traffic and asynchronous reset during a read wait.
module tb_ahb_req_concatenator;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        wfull;
    logic        winc;
    logic [71:0] conc_data_fifo;
    logic        rd_rempty;
    logic [31:0] rd_rdata;
    logic        rd_rinc;

    int tests = 0;
    int fails = 0;

    always #5 wclk = ~wclk;
    assign HREADY = HREADYOUT;

    ahb_req_concatenator dut (
        .wclk           (wclk),
        .wrst           (wrst),
        .HSEL           (HSEL),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HADDR          (HADDR),
        .HSIZE          (HSIZE),
        .HPROT          (HPROT),
        .HWDATA         (HWDATA),
        .HREADY         (HREADY),
        .HREADYOUT      (HREADYOUT),
        .HRESP          (HRESP),
        .HRDATA         (HRDATA),
        .wfull          (wfull),
        .winc           (winc),
        .conc_data_fifo (conc_data_fifo),
        .rd_rempty      (rd_rempty),
        .rd_rdata       (rd_rdata),
        .rd_rinc        (rd_rinc)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                              input logic [3:0] prot);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = a;
        HSIZE  = sz;
        HPROT  = prot;
    endtask

    task automatic bus_idle();
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    function automatic logic [71:0] word(input logic [31:0] d, input logic [3:0] s,
                                         input logic [2:0] p, input logic [31:0] a,
                                         input logic w);
        return {d, s, p, a, w};
    endfunction

    initial begin
        wrst = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
        HSIZE = 3'd2; HPROT = 4'd0; HWDATA = '0; wfull = 1'b0; rd_rempty = 1'b1;
        rd_rdata = 32'h0BAD_0BAD;

        // Reset values
        @(negedge wclk);
        check("rst_hreadyout", 72'(HREADYOUT), 72'(1'b1));
        check("rst_winc", 72'(winc), 72'(1'b0));
        check("rst_rinc", 72'(rd_rinc), 72'(1'b0));
        check("rst_hrdata", 72'(HRDATA), 72'(0));
        check("rst_word", conc_data_fifo, 72'(0));
        check("hresp", 72'(HRESP), 72'(1'b0));
        tick();
        wrst = 1'b0;

        // Single word write
        addr_phase(1'b1, 32'h4000_0010, 3'd2, 4'b0011);
        tick();
        bus_idle(); HWDATA = 32'hDEAD_BEEF;
        @(negedge wclk);
        check("wr_winc", 72'(winc), 72'(1'b1));
        check("wr_hreadyout", 72'(HREADYOUT), 72'(1'b1));
        check("wr_word", conc_data_fifo, word(32'hDEADBEEF, 4'hF, 3'b001, 32'h40000010, 1'b1));
        tick();
        @(negedge wclk);
        check("wr_done_winc", 72'(winc), 72'(1'b0));

        // Byte write at offset 3
        addr_phase(1'b1, 32'h4000_0003, 3'd0, 4'b0000);
        tick();
        bus_idle(); HWDATA = 32'h1122_3344;
        @(negedge wclk);
        check("byte_word", conc_data_fifo, word(32'h11223344, 4'b1000, 3'b100, 32'h40000003, 1'b1));

        // Halfword write at offset 2, chained directly behind the byte write
        addr_phase(1'b1, 32'h4000_0002, 3'd1, 4'b0010);
        tick();
        bus_idle(); HWDATA = 32'hCAFE_F00D;
        @(negedge wclk);
        check("half_winc", 72'(winc), 72'(1'b1));
        check("half_word", conc_data_fifo, word(32'hCAFEF00D, 4'b1100, 3'b101, 32'h40000002, 1'b1));
        tick();

        // Write stalled by a full FIFO for three cycles
        addr_phase(1'b1, 32'h4000_0020, 3'd2, 4'b0011);
        tick();
        bus_idle(); HWDATA = 32'h5555_AAAA; wfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            check("full_hreadyout", 72'(HREADYOUT), 72'(1'b0));
            check("full_winc", 72'(winc), 72'(1'b0));
            tick();
        end
        wfull = 1'b0;
        @(negedge wclk);
        check("full_rel_winc", 72'(winc), 72'(1'b1));
        check("full_rel_hready", 72'(HREADYOUT), 72'(1'b1));
        check("full_rel_word", conc_data_fifo, word(32'h5555AAAA, 4'hF, 3'b001, 32'h40000020, 1'b1));
        tick();
        @(negedge wclk);
        check("full_single_push", 72'(winc), 72'(1'b0));

        // Read with response arriving four cycles after the push
        addr_phase(1'b0, 32'h4000_0004, 3'd2, 4'b0011);
        tick();
        bus_idle(); HWDATA = 32'hFFFF_FFFF;
        @(negedge wclk);
        check("rd_push_winc", 72'(winc), 72'(1'b1));
        check("rd_push_hready", 72'(HREADYOUT), 72'(1'b0));
        check("rd_push_word", conc_data_fifo, word(32'h0, 4'h0, 3'b001, 32'h40000004, 1'b0));
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            check("rwait_hready", 72'(HREADYOUT), 72'(1'b0));
            check("rwait_rinc", 72'(rd_rinc), 72'(1'b0));
            check("rwait_winc", 72'(winc), 72'(1'b0));
            tick();
        end
        rd_rempty = 1'b0; rd_rdata = 32'h1234_5678;
        @(negedge wclk);
        check("rd_hrdata", 72'(HRDATA), 72'(32'h12345678));
        check("rd_hready", 72'(HREADYOUT), 72'(1'b1));
        check("rd_rinc", 72'(rd_rinc), 72'(1'b1));
        tick();
        rd_rempty = 1'b1;
        @(negedge wclk);
        check("rd_after_rinc", 72'(rd_rinc), 72'(1'b0));
        check("rd_after_hrdata", 72'(HRDATA), 72'(0));
        check("rd_after_hready", 72'(HREADYOUT), 72'(1'b1));

        // Four back-to-back NONSEQ writes
        addr_phase(1'b1, 32'h0000_0100, 3'd2, 4'b0000);
        tick();
        for (int k = 1; k <= 4; k++) begin
            HWDATA = 32'hA0 + 32'(k - 1);
            if (k < 4) addr_phase(1'b1, 32'h0000_0100 + 32'(4 * k), 3'd2, 4'b0000);
            else bus_idle();
            @(negedge wclk);
            check("b2b_winc", 72'(winc), 72'(1'b1));
            check("b2b_hready", 72'(HREADYOUT), 72'(1'b1));
            check("b2b_word", conc_data_fifo,
                  word(32'hA0 + 32'(k - 1), 4'hF, 3'b100, 32'h100 + 32'(4 * (k - 1)), 1'b1));
            tick();
        end
        @(negedge wclk);
        check("idle_gap_winc", 72'(winc), 72'(1'b0));
        tick();

        // Write followed directly by a read
        addr_phase(1'b1, 32'h0000_0200, 3'd2, 4'b0000);
        tick();
        HWDATA = 32'h77;
        addr_phase(1'b0, 32'h0000_0204, 3'd2, 4'b0000);
        @(negedge wclk);
        check("wr2rd_wword", conc_data_fifo, word(32'h77, 4'hF, 3'b100, 32'h200, 1'b1));
        tick();
        bus_idle();
        @(negedge wclk);
        check("wr2rd_rword", conc_data_fifo, word(32'h0, 4'h0, 3'b100, 32'h204, 1'b0));
        tick();
        rd_rempty = 1'b0; rd_rdata = 32'h99;
        @(negedge wclk);
        check("wr2rd_hrdata", 72'(HRDATA), 72'(32'h99));
        check("wr2rd_rinc", 72'(rd_rinc), 72'(1'b1));
        tick();
        rd_rempty = 1'b1;

        // Asynchronous reset in the middle of RWAIT
        addr_phase(1'b0, 32'h0000_0300, 3'd2, 4'b0011);
        tick();
        bus_idle();
        tick();
        @(negedge wclk);
        check("pre_rst_hready", 72'(HREADYOUT), 72'(1'b0));
        #2;
        wrst = 1'b1; rd_rempty = 1'b0; rd_rdata = 32'hFEED_FACE;
        #1;
        check("arst_hready", 72'(HREADYOUT), 72'(1'b1));
        check("arst_rinc", 72'(rd_rinc), 72'(1'b0));
        check("arst_hrdata", 72'(HRDATA), 72'(0));
        check("arst_winc", 72'(winc), 72'(1'b0));
        check("arst_word", conc_data_fifo, 72'(0));
        tick();
        wrst = 1'b0; rd_rempty = 1'b1;

        // Next read after reset release completes normally
        addr_phase(1'b0, 32'h0000_0304, 3'd2, 4'b0011);
        tick();
        bus_idle();
        @(negedge wclk);
        check("post_rst_winc", 72'(winc), 72'(1'b1));
        check("post_rst_word", conc_data_fifo, word(32'h0, 4'h0, 3'b001, 32'h304, 1'b0));
        tick();
        rd_rempty = 1'b0; rd_rdata = 32'hBEEF_0001;
        @(negedge wclk);
        check("post_rst_hrdata", 72'(HRDATA), 72'(32'hBEEF0001));
        check("post_rst_rinc", 72'(rd_rinc), 72'(1'b1));
        check("post_rst_hready", 72'(HREADYOUT), 72'(1'b1));
        tick();
        rd_rempty = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
